seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the shared BCD-to-7-segment decoder (inputs A,B,C,D; outputs a..g,dp).
//  Sequences NUM_DIGITS digits onto the one decoder and drives active-low digit enables.
//  Inserts a blanking interval at the start of every digit slot to suppress ghosting.
//  Takes new display values through a load/ack handshake that applies them only at frame boundaries (tear-free).
// PARAMETERS
//  NUM_DIGITS  4      digits scanned per frame (>=2)
//  TICK_DIV    50000  clk cycles per digit slot (>=2)
//  BLANK_CYC   16     cycles at slot start with all digits off (0 <= BLANK_CYC < TICK_DIV)
// PORTS
//  clk        in   1             single clock; all state changes on rising edge
//  rst        in   1             synchronous, active-high reset
//  en         in   1             scan enable; low = display dark
//  load       in   1             1-cycle strobe: capture data/dp_mask as pending frame
//  data       in   4*NUM_DIGITS  digit i = data[4i+3:4i]
//  dp_mask    in   NUM_DIGITS    dp_mask[i]=1 lights dp on digit i
//  A,B,C,D    out  1 each        nibble to decoder; A=nibble[3] ... D=nibble[0]
//  dp         out  1             decimal point for the current digit
//  digit_sel  out  NUM_DIGITS    active-low digit enables; at most one bit low
//  frame_done out  1             1-cycle pulse after the last slot of a frame
//  load_ack   out  1             1-cycle pulse: pending frame now displayed
// BEHAVIOUR
//  Reset: state BLANK, idx=0, prescaler=0, shadow=0, pending=0, pend=0, A..D=0, dp=0, digit_sel=all 1, frame_done=0, load_ack=0.
//  Reset mid-operation: all of the above takes effect on the next edge; the pending frame is discarded.
//  All outputs are registered; no combinational path from inputs to outputs.
//  Prescaler: counts 0..TICK_DIV-1 while en=1. Slot end (SE) = prescaler==TICK_DIV-1.
//  FSM states:
//   BLANK: digit_sel=all 1; A..D/dp = shadow[idx]. Exit to SHOW when prescaler==BLANK_CYC-1 (immediately if BLANK_CYC=0).
//   SHOW:  digit_sel[idx]=0, all other bits 1. Exit on SE.
//  On SE: prescaler->0, idx->idx+1 (wraps NUM_DIGITS-1 -> 0), state->BLANK.
//  Frame boundary (FB) = SE && idx==NUM_DIGITS-1 && en.
//  Load handshake:
//   load && !FB: pending<=data/dp_mask, pend<=1. A second load before FB overwrites pending (last wins); only one ack results.
//   On FB: if load, shadow<=data directly (load wins over pend); else if pend, shadow<=pending. Then pend<=0.
//   frame_done<=1 on the FB edge, else 0. load_ack<=(load||pend) on the FB edge, else 0. Both pulse in the cycle after FB.
//   The first slot of the new frame (idx 0) shows the new shadow.
//  en=0: on the next edge digit_sel=all 1, state=BLANK, prescaler=0; idx, shadow and pending are held.
//   load is still accepted into pending. No FB occurs while en=0.
//   When en returns to 1, the scan resumes at the held idx with a full slot (BLANK first).
//  Widths: prescaler = $clog2(TICK_DIV); idx = max(1,$clog2(NUM_DIGITS)). idx must never reach NUM_DIGITS for non-power-of-2 NUM_DIGITS.
//  Counters saturate nowhere; every wrap is explicit.
// STRUCTURE
//  Shared package/include seg7_pkg: FSM state encodings (ST_BLANK, ST_SHOW), DIGIT_OFF level constant (1'b1), nibble width (4).
//  One sub-module, seg7_slot_timer: prescaler plus idx counter; outputs SE and FB; inputs clk, rst, en.
//  Top-level contents: FSM, shadow/pending registers, nibble/dp mux, output registers.
//  The decoder is instantiated by the parent; seg7_scan_ctrl does not contain it.
// TESTING  (NUM_DIGITS=4, TICK_DIV=8, BLANK_CYC=2)
//  1 Reset: rst=1 for 3 cycles, en=1 -> digit_sel=4'b1111, ABCD=0, dp=0, frame_done=0, load_ack=0 throughout.
//  2 Scan: load data=16'h4321, dp_mask=4'b0100, en=1 ->
//     after the first FB, slots show digit_sel 1110/1101/1011/0111 with ABCD=1,2,3,4;
//     each slot is 2 cycles 1111 then 6 cycles selected; dp=1 only in slot 2; frame_done every 32 cycles.
//  3 Mid-frame load: load 16'hABCD at cycle 10 of a frame -> old digits shown until FB;
//     load_ack and frame_done high together for 1 cycle; next frame shows D,C,B,A.
//  4 Double load: 16'h1234 then 16'h5678 in one frame -> exactly one load_ack; 5678 displayed.
//  5 Load coincident with FB -> applied at that FB; load_ack the following cycle; no stale pend ack next frame.
//  6 en low during SHOW of idx 2 -> digit_sel=1111 next cycle. en high -> BLANK 2 cycles, then digit_sel=1011.
//     Also check: rst during SHOW -> reset values next cycle and the pending load is lost (no ack).

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan FSM state encodings, digit-off level and nibble width
package seg7_pkg;
  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;
  localparam logic DIGIT_OFF = 1'b1;
  localparam int NIB_W = 4;
endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: slot prescaler and digit index (in clk/rst/en; out pre, idx_nxt, slot end se, frame boundary fb)
module seg7_slot_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic [$clog2(TICK_DIV)-1:0] pre,
  output logic [$clog2(NUM_DIGITS)-1:0] idx_nxt,
  output logic se,
  output logic fb
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [IW-1:0] idx;
  always_comb begin
    se = en && pre == PW'(TICK_DIV - 1);
    fb = se && idx == IW'(NUM_DIGITS - 1);
    idx_nxt = !se ? idx : fb ? '0 : idx + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= (se || !en) ? '0 : pre + 1'b1;
      idx <= idx_nxt;
    end
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-seg scan (in clk/rst/en/load/data/dp_mask; out A..D/dp nibble, active-low digit_sel, frame_done, load_ack)
module seg7_scan_ctrl import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic [NIB_W*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic dp,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic frame_done,
  output logic load_ack
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = NIB_W * NUM_DIGITS;
  state_t state, state_nxt;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx_nxt;
  logic se, fb, blank_end, pend;
  logic [DW-1:0] shadow, pending, shadow_nxt;
  logic [NUM_DIGITS-1:0] shadow_dp, pending_dp, shadow_dp_nxt, sel_nxt;
  logic [NIB_W-1:0] nib_nxt;
  seg7_slot_timer #(.NUM_DIGITS(NUM_DIGITS), .TICK_DIV(TICK_DIV)) u_timer (
    .clk(clk),
    .rst(rst),
    .en(en),
    .pre(pre),
    .idx_nxt(idx_nxt),
    .se(se),
    .fb(fb)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= ST_BLANK;
    else state <= state_nxt;
  end
  always_comb begin
    blank_end = (BLANK_CYC == 0) || (pre == PW'(BLANK_CYC - 1));
    state_nxt = !en ? ST_BLANK
              : se ? (BLANK_CYC == 0 ? ST_SHOW : ST_BLANK)
              : (state == ST_BLANK && blank_end) ? ST_SHOW : state;
  end
  always_comb begin
    shadow_nxt = fb ? (load ? data : pend ? pending : shadow) : shadow;
    shadow_dp_nxt = fb ? (load ? dp_mask : pend ? pending_dp : shadow_dp) : shadow_dp;
    nib_nxt = shadow_nxt[NIB_W*idx_nxt +: NIB_W];
    sel_nxt = {NUM_DIGITS{DIGIT_OFF}};
    if (state_nxt == ST_SHOW) sel_nxt[idx_nxt] = ~DIGIT_OFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      shadow_dp <= '0;
      pending <= '0;
      pending_dp <= '0;
      pend <= 1'b0;
      {A, B, C, D} <= '0;
      dp <= 1'b0;
      digit_sel <= {NUM_DIGITS{DIGIT_OFF}};
      frame_done <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      shadow_dp <= shadow_dp_nxt;
      if (load && !fb) begin
        pending <= data;
        pending_dp <= dp_mask;
      end
      pend <= !fb && (load || pend);
      {A, B, C, D} <= nib_nxt;
      dp <= shadow_dp_nxt[idx_nxt];
      digit_sel <= sel_nxt;
      frame_done <= fb;
      load_ack <= fb && (load || pend);
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scenario tests plus random stimulus against a slot-position reference model
module tb_seg7_scan_ctrl;
  localparam int N = 4, TD = 8, BC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0] dp_mask = '0;
  logic A, B, C, D, dp, frame_done, load_ack;
  logic [3:0] digit_sel;
  int vectors = 0, errors = 0;
  int m_pos, m_idx;
  logic [15:0] m_disp, m_pdata;
  logic [3:0] m_dpd, m_pdp;
  logic m_pend, m_fd, m_ack;
  seg7_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp_mask(dp_mask),
    .A(A), .B(B), .C(C), .D(D), .dp(dp), .digit_sel(digit_sel),
    .frame_done(frame_done), .load_ack(load_ack)
  );
  always #5 clk = ~clk;
  function automatic logic [10:0] obs();
    return {digit_sel, A, B, C, D, dp, frame_done, load_ack};
  endfunction
  function automatic logic [10:0] expv();
    logic [3:0] one, sel;
    one = 4'b1;
    sel = (m_pos >= BC) ? ~(one << m_idx) : 4'hF;
    return {sel, m_disp[4*m_idx +: 4], m_dpd[m_idx], m_fd, m_ack};
  endfunction
  task automatic tick(input logic r, input logic e, input logic l, input logic [15:0] d, input logic [3:0] m);
    rst = r; en = e; load = l; data = d; dp_mask = m;
    @(posedge clk);
    if (r) begin
      m_pos = 0; m_idx = 0; m_disp = '0; m_dpd = '0; m_pdata = '0; m_pdp = '0;
      m_pend = 0; m_fd = 0; m_ack = 0;
    end else if (!e) begin
      m_pos = 0; m_fd = 0; m_ack = 0;
      if (l) begin m_pend = 1; m_pdata = d; m_pdp = m; end
    end else begin
      m_fd = (m_pos == TD-1) && (m_idx == N-1);
      m_ack = m_fd && (l || m_pend);
      if (m_fd) begin
        if (l) begin m_disp = d; m_dpd = m; end
        else if (m_pend) begin m_disp = m_pdata; m_dpd = m_pdp; end
        m_pend = 0;
      end else if (l) begin m_pend = 1; m_pdata = d; m_pdp = m; end
      if (m_pos == TD-1) begin m_pos = 0; m_idx = (m_idx + 1) % N; end
      else m_pos++;
    end
    #1;
  endtask
  task automatic run();
    tick(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      vectors++;
      if (obs() !== 11'b1111_0000_000) begin errors++; $display("FAIL reset: got %b want %b", obs(), 11'b1111_0000_000); end
    end
  endtask
  task automatic test_scan();
    logic found;
    logic [3:0] one, sel;
    logic [10:0] e;
    int s, p;
    one = 4'b1;
    found = 0;
    tick(1'b0, 1'b1, 1'b1, 16'h4321, 4'b0100);
    vectors++;
    if (obs() !== expv()) begin errors++; $display("FAIL scan_load: got %b want %b", obs(), expv()); end
    for (int i = 0; i < 40 && !found; i++) begin
      run();
      vectors++;
      if (obs() !== expv()) begin errors++; $display("FAIL scan_model: got %b want %b", obs(), expv()); end
      found = frame_done;
    end
    vectors++;
    if (found !== 1'b1) begin errors++; $display("FAIL scan_first_fb: got %b want 1", found); end
    for (int c = 1; c <= 32; c++) begin
      run();
      s = (c / 8) % 4;
      p = c % 8;
      sel = (p < 2) ? 4'hF : ~(one << s);
      e = {sel, 4'(s + 1), (s == 2), (c == 32), 1'b0};
      vectors++;
      if (obs() !== e) begin errors++; $display("FAIL scan_frame c=%0d: got %b want %b", c, obs(), e); end
    end
  endtask
  task automatic test_midload();
    logic found;
    found = 0;
    for (int i = 0; i < 9; i++) begin
      run();
      vectors++;
      if (obs() !== expv()) begin errors++; $display("FAIL midload_pre: got %b want %b", obs(), expv()); end
    end
    tick(1'b0, 1'b1, 1'b1, 16'hABCD, 4'h0);
    for (int i = 0; i < 40 && !found; i++) begin
      run();
      vectors++;
      if (obs() !== expv()) begin errors++; $display("FAIL midload_model: got %b want %b", obs(), expv()); end
      found = frame_done;
    end
    vectors++;
    if ({frame_done, load_ack} !== 2'b11) begin errors++; $display("FAIL midload_ack: got %b want 11", {frame_done, load_ack}); end
    run();
    run();
    vectors++;
    if ({digit_sel, A, B, C, D} !== {4'b1110, 4'hD}) begin errors++; $display("FAIL midload_digit0: got %h want ED", {digit_sel, A, B, C, D}); end
  endtask
  task automatic test_double_load();
    int acks;
    acks = 0;
    tick(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0011);
    for (int i = 0; i < 5; i++) run();
    tick(1'b0, 1'b1, 1'b1, 16'h5678, 4'b1000);
    for (int i = 0; i < 60; i++) begin
      run();
      acks += int'(load_ack);
      vectors++;
      if (obs() !== expv()) begin errors++; $display("FAIL double_model: got %b want %b", obs(), expv()); end
    end
    vectors++;
    if (acks != 1) begin errors++; $display("FAIL double_acks: got %0d want 1", acks); end
  endtask
  task automatic test_fb_load();
    int acks;
    logic found;
    acks = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_pos == TD-1 && m_idx == N-1) found = 1;
      else run();
    end
    vectors++;
    if (found !== 1'b1) begin errors++; $display("FAIL fbload_sync: got %b want 1", found); end
    tick(1'b0, 1'b1, 1'b1, 16'h9876, 4'b0001);
    vectors++;
    if ({frame_done, load_ack} !== 2'b11) begin errors++; $display("FAIL fbload_ack: got %b want 11", {frame_done, load_ack}); end
    for (int i = 0; i < 33; i++) begin
      run();
      acks += int'(load_ack);
      vectors++;
      if (obs() !== expv()) begin errors++; $display("FAIL fbload_model: got %b want %b", obs(), expv()); end
    end
    vectors++;
    if (acks != 0) begin errors++; $display("FAIL fbload_stale: got %0d acks want 0", acks); end
  endtask
  task automatic test_enable_and_reset();
    int acks;
    logic found;
    acks = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_idx == 2 && m_pos == 4) found = 1;
      else run();
    end
    vectors++;
    if (digit_sel !== 4'b1011) begin errors++; $display("FAIL en_show: got %b want 1011", digit_sel); end
    tick(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    vectors++;
    if (digit_sel !== 4'hF) begin errors++; $display("FAIL en_off: got %b want 1111", digit_sel); end
    tick(1'b0, 1'b0, 1'b1, 16'h1111, 4'b1000);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    vectors++;
    if (obs() !== expv()) begin errors++; $display("FAIL en_hold: got %b want %b", obs(), expv()); end
    run();
    vectors++;
    if (digit_sel !== 4'hF) begin errors++; $display("FAIL en_blank: got %b want 1111", digit_sel); end
    run();
    vectors++;
    if (digit_sel !== 4'b1011) begin errors++; $display("FAIL en_resume: got %b want 1011", digit_sel); end
    tick(1'b0, 1'b1, 1'b1, 16'h2222, 4'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_pos == 5) found = 1;
      else run();
    end
    tick(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    vectors++;
    if (obs() !== 11'b1111_0000_000) begin errors++; $display("FAIL rst_mid: got %b want %b", obs(), 11'b1111_0000_000); end
    for (int i = 0; i < 40; i++) begin
      run();
      acks += int'(load_ack);
      vectors++;
      if (obs() !== expv()) begin errors++; $display("FAIL rst_model: got %b want %b", obs(), expv()); end
    end
    vectors++;
    if (acks != 0) begin errors++; $display("FAIL rst_lost_load: got %0d acks want 0", acks); end
  endtask
  task automatic test_random();
    logic r, e, l;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 15) == 0);
      tick(r, e, l, 16'($urandom), 4'($urandom));
      vectors++;
      if (obs() !== expv()) begin errors++; $display("FAIL random cyc=%0d: got %b want %b", i, obs(), expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_midload();
    test_double_load();
    test_fb_load();
    test_enable_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
